alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Downstream neighbour of the ALU: captures each ALU result (aluOut, carry, flags) with its destination register address and buffers it in a small in-order FIFO.
- Presents results to the register-file write port over a valid/ready handshake.
- Holds the architectural status register ({carry, flags}), updated in order at commit.
- Decouples ALU issue from writeback stalls without dropping results.

Parameters:
- DATA_W, 32, ALU result width.
- FLAG_W, 5, ALU flag vector width.
- ADDR_W, 5, destination register address width.
- DEPTH, 2, FIFO entries; must be a power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  ALU result valid.
- in_ready  out  1  stage can accept a result.
- in_data  in  DATA_W  ALU aluOut.
- in_carry  in  1  ALU carry.
- in_flags  in  FLAG_W  ALU flags.
- in_addr  in  ADDR_W  destination register.
- in_setf  in  1  result updates the status register at commit.
- wb_valid  out  1  head entry valid.
- wb_ready  in  1  register file accepts the head.
- wb_we  out  1  wb_valid AND wb_addr != 0.
- wb_data  out  DATA_W  head result.
- wb_addr  out  ADDR_W  head destination.
- status_q  out  FLAG_W+1  committed {carry, flags}.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - count, read pointer and write pointer go to 0.
  - wb_valid=0, wb_we=0, wb_data=0, wb_addr=0, status_q=0, in_ready=1.
  - FIFO contents are discarded.
- Push: in_valid && in_ready at a rising edge writes {data, carry, flags, addr, setf} at the write pointer, then the write pointer increments (wraps mod DEPTH).
- Pop: wb_valid && wb_ready at a rising edge increments the read pointer (wraps mod DEPTH).
- Pop commit: if the popped entry's setf=1, status_q <= {carry, flags} of that entry at the same edge. Otherwise status_q is held.
- Handshake signals:
  - in_ready = (count != DEPTH), combinational from registered count only. There is no path from wb_ready to in_ready.
  - wb_valid = (count != 0). wb_data and wb_addr show the head entry; they are zeroed when empty.
- Latency: an accepted result is visible on wb_* in the cycle after the push edge. With wb_ready held high, 1 result/cycle is sustained.
- Simultaneous push and pop, count between 1 and DEPTH-1: count is unchanged and both pointers advance.
- Full (count=DEPTH): in_ready=0. A pop that cycle frees space, but in_ready rises only in the next cycle.
- Empty (count=0): a push and no pop is possible. There is no same-cycle bypass to wb_*.
- Handshake stability:
  - Upstream holds in_* stable while in_valid && !in_ready.
  - The stage holds wb_* stable while wb_valid && !wb_ready.
- Destination 0: the entry is still queued and committed, and its status update is still applied, but wb_we=0.
- Flags become architectural only at commit, in program order. status_q never reflects a buffered, uncommitted result.
- Count arithmetic: width clog2(DEPTH)+1. Pointers: width clog2(DEPTH), natural wrap.

Optional Feature:
- Macro: ALU_RESULT_CNT_EN.
- Defined:
  - Adds output commit_cnt [15:0], reset 0.
  - Increments on every pop, including destination-0 entries, and wraps 16'hFFFF -> 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - DATA_W, FLAG_W and ADDR_W constants.
  - The flag bit index constants.
  - A result-entry typedef {data, carry, flags, addr, setf}.
- One natural sub-module: alu_result_fifo, a generic DEPTH-entry in-order FIFO with count-based full/empty.
- The top-level adds status commit, wb_we gating and the optional counter.

Test Plan:
- Reset then idle: rst=1 -> all outputs 0 and in_ready=1. Release rst -> wb_valid stays 0.
- Single pass: push data=32'h0000_0005, carry=1, flags=5'b00010, addr=3, setf=1, with wb_ready=1.
  - Next cycle: wb_valid=1, wb_data=5, wb_addr=3, wb_we=1.
  - After the pop edge: status_q=6'b1_00010.
- Backpressure: wb_ready=0, push 3 results A, B, C.
  - A and B accepted; in_ready=0 with C held.
  - Release wb_ready -> pops occur in order A, B, then C is accepted and popped. No loss or duplication.
- Streaming: in_valid=1 and wb_ready=1 for 10 cycles with random data -> 10 commits, in order, and count never exceeds 1.
- Destination 0 with setf=0: push addr=0, data=32'hDEAD_BEEF -> wb_valid=1, wb_we=0, status_q unchanged.
- Reset mid-operation: FIFO full, assert rst asynchronously between edges -> wb_valid drops immediately and status_q=0. With ALU_RESULT_CNT_EN defined, commit_cnt=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: datapath widths, flag bit
// positions and the packed result entry that travels through the FIFO.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int FLAG_W = 5;
  localparam int ADDR_W = 5;

  // Bit positions inside the ALU flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_P = 3;
  localparam int FLAG_H = 4;

  // One buffered ALU result, waiting for commit.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              carry;
    logic [FLAG_W-1:0] flags;
    logic [ADDR_W-1:0] addr;
    logic              setf;
  } result_entry_t;

  localparam int ENTRY_W = $bits(result_entry_t);

endpackage

// File: rtl/alu_result_fifo.sv
// Generic DEPTH-entry in-order FIFO with count-based full/empty and a
// valid/ready interface on both sides. The head is forced to zero when empty.
module alu_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [WIDTH-1:0] o_rd_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_push;
  logic             w_pop;

  // Ready/valid come from the registered count only, so there is no
  // combinational path from the read side to the write side.
  assign o_wr_ready = (r_count != CNT_W'(DEPTH));
  assign o_rd_valid = (r_count != '0);
  assign w_push     = i_wr_valid && o_wr_ready;
  assign w_pop      = o_rd_valid && i_rd_ready;
  assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : '0;

  // Next occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers and count; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // Storage write on an accepted push.
  // NOTE: the storage array has no reset; stale contents are unreachable because
  // the head is gated by the count, and leaving it unreset keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers ALU results in an in-order FIFO, presents them to
// the register-file write port and commits {carry, flags} to the status
// register when a result with setf is popped.
// Optional feature: define ALU_RESULT_CNT_EN to add the 16-bit commit_cnt output.
// Datapath widths follow alu_pkg; the width parameters are exposed for visibility.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int FLAG_W = alu_pkg::FLAG_W,
  parameter int ADDR_W = alu_pkg::ADDR_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_carry,
  input  logic [FLAG_W-1:0] in_flags,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_setf,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [FLAG_W:0]   status_q
`ifdef ALU_RESULT_CNT_EN
  ,
  output logic [15:0]       commit_cnt
`endif
);

  result_entry_t w_in_entry;
  result_entry_t w_head;
  logic          w_pop;
  logic [FLAG_W:0] r_status;

  assign w_in_entry = '{data: in_data, carry: in_carry, flags: in_flags,
                        addr: in_addr, setf: in_setf};

  alu_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (in_valid),
    .o_wr_ready (in_ready),
    .i_wr_data  (w_in_entry),
    .o_rd_valid (wb_valid),
    .i_rd_ready (wb_ready),
    .o_rd_data  (w_head)
  );

  assign w_pop    = wb_valid && wb_ready;
  assign wb_data  = w_head.data;
  assign wb_addr  = w_head.addr;
  // Register 0 is never written, but the entry still commits its flags.
  assign wb_we    = wb_valid && (w_head.addr != '0);
  assign status_q = r_status;

  // Status commit: flags become architectural only when their result pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_status <= '0;
    end else if (w_pop && w_head.setf) begin
      r_status <= {w_head.carry, w_head.flags};
    end
  end

`ifdef ALU_RESULT_CNT_EN
  logic [15:0] r_commit_cnt;

  // Commit counter: every pop counts, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_commit_cnt <= '0;
    end else if (w_pop) begin
      r_commit_cnt <= r_commit_cnt + 16'd1;
    end
  end

  assign commit_cnt = r_commit_cnt;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: stimulus pushes expected entries into
// a queue when a result is accepted; a negedge monitor pops and compares on
// every writeback handshake and tracks the expected status register.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_carry;
  logic [4:0]  in_flags;
  logic [4:0]  in_addr;
  logic        in_setf;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_we;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic [5:0]  status_q;
`ifdef ALU_RESULT_CNT_EN
  logic [15:0] commit_cnt;
`endif

  alu_result_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_carry   (in_carry),
    .in_flags   (in_flags),
    .in_addr    (in_addr),
    .in_setf    (in_setf),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_we      (wb_we),
    .wb_data    (wb_data),
    .wb_addr    (wb_addr),
    .status_q   (status_q)
`ifdef ALU_RESULT_CNT_EN
    ,
    .commit_cnt (commit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  int            n_pops   = 0;
  result_entry_t exp_q[$];
  logic [5:0]    exp_status = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: status register every cycle, head contents on each pop.
  always @(negedge clk) begin
    if (!rst) begin
      check("status_q", 64'(status_q), 64'(exp_status));
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pop: got data %0h with empty scoreboard", wb_data);
        end else begin
          result_entry_t e;
          e = exp_q.pop_front();
          check("wb_data", 64'(wb_data), 64'(e.data));
          check("wb_addr", 64'(wb_addr), 64'(e.addr));
          check("wb_we",   64'(wb_we),   64'(e.addr != 5'd0));
          if (e.setf) exp_status = {e.carry, e.flags};
          n_pops++;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one result and hold it until accepted; expectation enters the
  // scoreboard just before the accepting edge.
  task automatic push(input logic [31:0] d, input logic c, input logic [4:0] f,
                      input logic [4:0] a, input logic s);
    int waited = 0;
    in_data  = d;
    in_carry = c;
    in_flags = f;
    in_addr  = a;
    in_setf  = s;
    in_valid = 1'b1;
    while (!in_ready && waited < 20) begin
      next_cycle();
      waited++;
    end
    if (!in_ready) begin
      check("push_timeout", 64'(in_ready), 64'd1);
    end else begin
      exp_q.push_back('{data: d, carry: c, flags: f, addr: a, setf: s});
      next_cycle();
    end
    in_valid = 1'b0;
  endtask

  // Wait for the scoreboard to drain, bounded.
  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      next_cycle();
      waited++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int pops_before;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_carry = 1'b0;
    in_flags = '0;
    in_addr  = '0;
    in_setf  = 1'b0;
    wb_ready = 1'b0;

    // Reset state.
    #2;
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_we",    64'(wb_we),    64'd0);
    check("rst_wb_data",  64'(wb_data),  64'd0);
    check("rst_wb_addr",  64'(wb_addr),  64'd0);
    check("rst_status",   64'(status_q), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ALU_RESULT_CNT_EN
    check("rst_commit_cnt", 64'(commit_cnt), 64'd0);
`endif
    @(posedge clk);
    #3 rst = 1'b0;
    next_cycle();
    next_cycle();
    check("idle_wb_valid", 64'(wb_valid), 64'd0);

    // Single pass.
    wb_ready = 1'b1;
    push(32'h0000_0005, 1'b1, 5'b00010, 5'd3, 1'b1);
    check("single_wb_valid", 64'(wb_valid), 64'd1);
    check("single_wb_data",  64'(wb_data),  64'd5);
    check("single_wb_addr",  64'(wb_addr),  64'd3);
    check("single_wb_we",    64'(wb_we),    64'd1);
    next_cycle();
    check("single_status",   64'(status_q), 64'(6'b1_00010));
    check("single_empty",    64'(wb_valid), 64'd0);

    // Backpressure: A and B fill the FIFO, C must wait.
    wb_ready = 1'b0;
    push(32'hA0A0_0001, 1'b0, 5'b00001, 5'd1, 1'b1);
    push(32'hB0B0_0002, 1'b1, 5'b11111, 5'd2, 1'b0);
    in_data  = 32'hC0C0_0003;
    in_carry = 1'b1;
    in_flags = 5'b10100;
    in_addr  = 5'd4;
    in_setf  = 1'b1;
    in_valid = 1'b1;
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    next_cycle();
    check("bp_hold_in_ready", 64'(in_ready), 64'd0);
    check("bp_hold_wb_data",  64'(wb_data),  64'hA0A0_0001);
    wb_ready = 1'b1;
    check("bp_no_comb_path",  64'(in_ready), 64'd0);
    next_cycle();
    check("bp_ready_rises",   64'(in_ready), 64'd1);
    check("bp_head_b",        64'(wb_data),  64'hB0B0_0002);
    exp_q.push_back('{data: 32'hC0C0_0003, carry: 1'b1, flags: 5'b10100, addr: 5'd4, setf: 1'b1});
    next_cycle();
    in_valid = 1'b0;
    check("bp_head_c",        64'(wb_data),  64'hC0C0_0003);
    next_cycle();
    check("bp_empty",         64'(wb_valid), 64'd0);
    check("bp_status",        64'(status_q), 64'(6'b1_10100));

    // Streaming: one result per cycle, occupancy never above 1.
    pops_before = n_pops;
    for (int i = 0; i < 10; i++) begin
      logic [4:0] iv;
      iv = 5'(i);
      check("stream_in_ready", 64'(in_ready), 64'd1);
      push(32'h5000_0000 ^ (32'(i) * 32'h0101_0101), iv[1], iv, 5'(i + 1), iv[0]);
    end
    next_cycle();
    check("stream_empty",  64'(wb_valid), 64'd0);
    check("stream_pops",   64'(n_pops - pops_before), 64'd10);
    check("stream_status", 64'(status_q), 64'(6'b0_01001));

    // Destination 0 with setf=0.
    wb_ready = 1'b0;
    push(32'hDEAD_BEEF, 1'b1, 5'b11111, 5'd0, 1'b0);
    check("dst0_wb_valid", 64'(wb_valid), 64'd1);
    check("dst0_wb_we",    64'(wb_we),    64'd0);
    check("dst0_wb_data",  64'(wb_data),  64'hDEAD_BEEF);
    wb_ready = 1'b1;
    next_cycle();
    check("dst0_empty",    64'(wb_valid), 64'd0);
    check("dst0_status",   64'(status_q), 64'(6'b0_01001));
    drain();
`ifdef ALU_RESULT_CNT_EN
    check("commit_cnt_total", 64'(commit_cnt), 64'(n_pops));
`endif

    // Reset mid-operation with the FIFO full.
    wb_ready = 1'b0;
    push(32'h1111_1111, 1'b1, 5'b00110, 5'd7, 1'b1);
    push(32'h2222_2222, 1'b0, 5'b01100, 5'd8, 1'b1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_wb_valid", 64'(wb_valid), 64'd1);
    #2 rst = 1'b1;
    exp_q.delete();
    exp_status = '0;
    #1;
    check("arst_wb_valid", 64'(wb_valid), 64'd0);
    check("arst_wb_we",    64'(wb_we),    64'd0);
    check("arst_wb_data",  64'(wb_data),  64'd0);
    check("arst_status",   64'(status_q), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
`ifdef ALU_RESULT_CNT_EN
    check("arst_commit_cnt", 64'(commit_cnt), 64'd0);
`endif
    next_cycle();
    rst = 1'b0;
    wb_ready = 1'b1;
    next_cycle();
    next_cycle();
    check("post_rst_wb_valid", 64'(wb_valid), 64'd0);
    check("scoreboard_empty",  64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
